// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampled bit timing feeding a circular byte FIFO.
// Sticky overrun/framing flags are cleared by clr_flags; a set event beats a clear.
module uart_rx_fifo #(
  parameter int SERIAL_WCNT = 100,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clr_flags,
  output logic                  rx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int CNT_W = $clog2(SERIAL_WCNT);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(SERIAL_WCNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(SERIAL_WCNT - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                state_q, state_d;
  logic                  rxd_meta_q, rxd_meta_d;
  logic                  rxd_s_q, rxd_s_d;
  logic [CNT_W-1:0]      bcnt_q, bcnt_d;
  logic [2:0]            bidx_q, bidx_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            mem_q [DEPTH];

  logic expire;
  logic push;
  logic ferr_set;
  logic pop_ok;
  logic full;
  logic wr_en;
  logic ovr_set;

  // Two-flop synchroniser; idle level is 1 so reset cannot fake a start bit.
  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
  end

  assign expire = (bcnt_q == '0);

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          bcnt_d  = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (rxd_s_q) begin
            state_d = IDLE;
          end else begin
            bcnt_d  = FULL_LOAD;
            bidx_d  = 3'd0;
            state_d = DATA;
          end
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      DATA: begin
        if (expire) begin
          shreg_d[bidx_q] = rxd_s_q;
          bcnt_d          = FULL_LOAD;
          bidx_d          = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = STOP;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      STOP: begin
        if (expire) begin
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: a pop frees the slot a simultaneous full-FIFO push needs.
  always_comb begin
    pop_ok   = pop && (cnt_q != '0);
    full     = (cnt_q == DEPTH_C);
    wr_en    = push && (!full || pop_ok);
    ovr_set  = push && full && !pop_ok;
    wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_en, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    overrun_d   = ovr_set  | (overrun_q   & ~clr_flags);
    frame_err_d = ferr_set | (frame_err_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      bcnt_q      <= '0;
      bidx_q      <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
      bcnt_q      <= bcnt_d;
      bidx_q      <= bidx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Datapath storage carries no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign dout      = mem_q[rd_ptr_q];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int WCNT = 8;
  localparam int DL2  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rxd = 1'b1;
  logic           pop = 1'b0;
  logic           clr_flags = 1'b0;
  logic [7:0]     dout;
  logic           empty;
  logic [DL2:0]   count;
  logic           overrun;
  logic           frame_err;
  logic           rx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.SERIAL_WCNT(WCNT), .DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .pop       (pop),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_flags (clr_flags),
    .rx_busy   (rx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop level so a framing test can hold it low.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    cyc(WCNT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(WCNT);
    end
    rxd = stop_bit;
    cyc(WCNT);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk(tag, 32'(dout), 32'(exp));
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
  endtask

  // rx_busy is first seen in cycle t+1; the push lands between t+76 and t+77.
  task automatic timed_frame(input logic [7:0] b, input logic do_pop, input logic do_clr,
                             input int cnt_before, input int cnt_after);
    fork
      send_frame(b, 1'b1);
      begin
        int n;
        n = 0;
        while (!rx_busy && n < 10) begin
          cyc(1);
          n++;
        end
        if (!rx_busy) begin
          chk("busy_rise", 32'(rx_busy), 32'd1);
        end else begin
          cyc(75);
          chk("cnt_before_push", 32'(count), 32'(cnt_before));
          pop       = do_pop;
          clr_flags = do_clr;
          cyc(1);
          pop       = 1'b0;
          clr_flags = 1'b0;
          chk("cnt_after_push", 32'(count), 32'(cnt_after));
        end
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    cyc(3);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    cyc(2);

    // single byte with exact push latency
    timed_frame(8'hA5, 1'b0, 1'b0, 0, 1);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_empty", 32'(empty), 32'd0);
    chk("single_ferr", 32'(frame_err), 32'd0);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    chk("single_pop_empty", 32'(empty), 32'd1);
    cyc(4);

    // glitch: two-cycle low pulse
    rxd = 1'b0;
    cyc(2);
    rxd = 1'b1;
    cyc(1);
    chk("glitch_busy_hi", 32'(rx_busy), 32'd1);
    cyc(12);
    chk("glitch_busy_lo", 32'(rx_busy), 32'd0);
    chk("glitch_count", 32'(count), 32'd0);
    chk("glitch_overrun", 32'(overrun), 32'd0);
    chk("glitch_ferr", 32'(frame_err), 32'd0);

    // overrun and pointer wrap
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    cyc(2);
    chk("ovr_count", 32'(count), 32'd4);
    chk("ovr_flag", 32'(overrun), 32'd1);
    pop_expect("ovr_rd1", 8'h01);
    pop_expect("ovr_rd2", 8'h02);
    pop_expect("ovr_rd3", 8'h03);
    pop_expect("ovr_rd4", 8'h04);
    chk("ovr_drained", 32'(empty), 32'd1);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    send_frame(8'h06, 1'b1);
    send_frame(8'h07, 1'b1);
    cyc(2);
    chk("wrap_count", 32'(count), 32'd2);
    pop_expect("wrap_rd6", 8'h06);
    pop_expect("wrap_rd7", 8'h07);
    chk("wrap_empty", 32'(empty), 32'd1);

    // framing error and break hold
    send_frame(8'h3C, 1'b0);
    cyc(3 * WCNT);
    chk("fe_flag", 32'(frame_err), 32'd1);
    chk("fe_count", 32'(count), 32'd0);
    chk("fe_wait_high", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    cyc(4);
    chk("fe_released", 32'(rx_busy), 32'd0);
    send_frame(8'h55, 1'b1);
    cyc(2);
    chk("fe_next_count", 32'(count), 32'd1);
    pop_expect("fe_next_dout", 8'h55);
    chk("fe_sticky", 32'(frame_err), 32'd1);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    chk("fe_cleared", 32'(frame_err), 32'd0);

    // simultaneous push-on-full with pop, and clear against overrun
    for (int b = 8'h11; b <= 8'h14; b++) send_frame(8'(b), 1'b1);
    cyc(2);
    chk("sim_full", 32'(count), 32'd4);
    timed_frame(8'h15, 1'b1, 1'b0, 4, 4);
    chk("sim_pop_no_ovr", 32'(overrun), 32'd0);
    chk("sim_head", 32'(dout), 32'h12);
    timed_frame(8'h16, 1'b0, 1'b1, 4, 4);
    chk("sim_set_wins", 32'(overrun), 32'd1);
    pop_expect("sim_rd12", 8'h12);
    pop_expect("sim_rd13", 8'h13);
    pop_expect("sim_rd14", 8'h14);
    pop_expect("sim_rd15", 8'h15);
    chk("sim_empty", 32'(empty), 32'd1);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;

    // reset mid-frame with a held byte and a set flag
    send_frame(8'h00, 1'b0);
    rxd = 1'b1;
    cyc(4);
    send_frame(8'h5A, 1'b1);
    cyc(2);
    chk("prerst_count", 32'(count), 32'd1);
    chk("prerst_ferr", 32'(frame_err), 32'd1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        cyc(WCNT + 3 * WCNT + 4);
        rst = 1'b1;
        cyc(1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_busy", 32'(rx_busy), 32'd0);
        chk("midrst_ferr", 32'(frame_err), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
      end
    join
    cyc(4);
    send_frame(8'h81, 1'b1);
    cyc(2);
    chk("postrst_count", 32'(count), 32'd1);
    pop_expect("postrst_dout", 8'h81);
    chk("postrst_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
